aes128_seq_ctrl: RTL and testbench

AES128_SEQ_CTRL -- requirements
Module: aes128_seq_ctrl

---
 rtl/aes128_ctrl_pkg.sv | 19 +
 rtl/aes128_round_cnt.sv | 40 ++++
 rtl/aes128_seq_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_aes128_seq_ctrl.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/aes128_ctrl_pkg.sv
// Shared types and constants for the AES-128 round sequencing controller.
// The state enumeration, round count, round-index width and key-expansion length live here.
package aes128_ctrl_pkg;

    localparam int NUM_ROUNDS = 10;
    localparam int RND_W      = 4;

    localparam logic [RND_W-1:0] KEYEXP_LEN = 4'd10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_KEYEXP,
        ST_LOAD,
        ST_ROUND,
        ST_FINAL,
        ST_DONE
    } state_e;

endpackage

// File: rtl/aes128_round_cnt.sv
// Loadable up/down round-index counter with a terminal-count compare.
// The next value is exported so the controller can register its round outputs in step with the count.
module aes128_round_cnt
    import aes128_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [RND_W-1:0] load_val,
    input  logic             en,
    input  logic             up,
    input  logic [RND_W-1:0] tc_val,
    output logic [RND_W-1:0] cnt_d,
    output logic             tc
);

    localparam logic [RND_W-1:0] ONE = RND_W'(1);

    logic [RND_W-1:0] cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (en) begin
            cnt_d = up ? (cnt_q + ONE) : (cnt_q - ONE);
        end
    end

    assign tc = (cnt_q == tc_val);

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/aes128_seq_ctrl.sv
// Sequencing controller for an iterative AES-128 datapath: key expansion, initial
// AddRoundKey load, the middle rounds, the final round and the result handshake.
//
// state  | meaning
// IDLE   | waiting for a job, in_ready high
// KEYEXP | 10 key-expansion steps, ke_round 1..10
// LOAD   | state <= text ^ round key 0 (enc) or 10 (dec)
// ROUND  | middle rounds, 1..9 (enc) or 9..1 (dec)
// FINAL  | last round without MixColumns
// DONE   | result valid, waiting for out_ready
module aes128_seq_ctrl #(
    parameter int NUM_ROUNDS = aes128_ctrl_pkg::NUM_ROUNDS
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_decrypt,
    input  logic        in_new_key,
    output logic        ke_en,
    output logic [3:0]  ke_round,
    output logic        dp_load,
    output logic        dp_en,
    output logic [3:0]  dp_round,
    output logic        dp_final,
    output logic        dp_decrypt,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        key_valid,
    output logic [15:0] jobs_done
);
    import aes128_ctrl_pkg::*;

    localparam logic [RND_W-1:0] LAST_RND  = RND_W'(NUM_ROUNDS);
    localparam logic [RND_W-1:0] PEN_RND   = RND_W'(NUM_ROUNDS - 1);
    localparam logic [RND_W-1:0] FIRST_RND = RND_W'(1);

    state_e      state_q, state_d;
    logic        in_ready_q, in_ready_d;
    logic        out_valid_q, out_valid_d;
    logic        ke_en_q, ke_en_d;
    logic [3:0]  ke_round_q, ke_round_d;
    logic        dp_load_q, dp_load_d;
    logic        dp_en_q, dp_en_d;
    logic [3:0]  dp_round_q, dp_round_d;
    logic        dp_final_q, dp_final_d;
    logic        dp_decrypt_q, dp_decrypt_d;
    logic        key_valid_q, key_valid_d;
    logic [15:0] jobs_done_q, jobs_done_d;

    logic        accept;
    logic        cnt_load, cnt_en, cnt_up, cnt_tc;
    logic [3:0]  cnt_load_val, cnt_tc_val, cnt_d;

    aes128_round_cnt u_round_cnt (
        .clk      (clk),
        .reset    (reset),
        .load     (cnt_load),
        .load_val (cnt_load_val),
        .en       (cnt_en),
        .up       (cnt_up),
        .tc_val   (cnt_tc_val),
        .cnt_d    (cnt_d),
        .tc       (cnt_tc)
    );

    assign accept = in_valid & in_ready_q;

    always_comb begin
        state_d      = state_q;
        key_valid_d  = key_valid_q;
        dp_decrypt_d = dp_decrypt_q;
        jobs_done_d  = jobs_done_q;
        cnt_load     = 1'b0;
        cnt_load_val = '0;
        cnt_en       = 1'b0;
        cnt_up       = ~dp_decrypt_q;
        cnt_tc_val   = KEYEXP_LEN;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    dp_decrypt_d = in_decrypt;
                    cnt_load     = 1'b1;
                    if (in_new_key || !key_valid_q) begin
                        state_d      = ST_KEYEXP;
                        key_valid_d  = 1'b0;
                        cnt_load_val = FIRST_RND;
                    end else begin
                        state_d      = ST_LOAD;
                        cnt_load_val = in_decrypt ? LAST_RND : '0;
                    end
                end
            end
            ST_KEYEXP: begin
                if (cnt_tc) begin
                    state_d      = ST_LOAD;
                    key_valid_d  = 1'b1;
                    cnt_load     = 1'b1;
                    cnt_load_val = dp_decrypt_q ? LAST_RND : '0;
                end else begin
                    cnt_en = 1'b1;
                    cnt_up = 1'b1;
                end
            end
            ST_LOAD: begin
                state_d = ST_ROUND;
                cnt_en  = 1'b1;
            end
            // Counting straight through into FINAL leaves the index at 10 (enc) or 0 (dec).
            ST_ROUND: begin
                cnt_en     = 1'b1;
                cnt_tc_val = dp_decrypt_q ? FIRST_RND : PEN_RND;
                if (cnt_tc) begin
                    state_d = ST_FINAL;
                end
            end
            ST_FINAL: begin
                state_d  = ST_DONE;
                cnt_load = 1'b1;
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d     = ST_IDLE;
                    jobs_done_d = jobs_done_q + 16'd1;
                end
            end
            default: begin
                state_d  = ST_IDLE;
                cnt_load = 1'b1;
            end
        endcase

        in_ready_d  = (state_d == ST_IDLE);
        out_valid_d = (state_d == ST_DONE);
        ke_en_d     = (state_d == ST_KEYEXP);
        ke_round_d  = (state_d == ST_KEYEXP) ? cnt_d : '0;
        dp_load_d   = (state_d == ST_LOAD);
        dp_en_d     = (state_d == ST_ROUND) || (state_d == ST_FINAL);
        dp_final_d  = (state_d == ST_FINAL);
        dp_round_d  = (dp_load_d || dp_en_d) ? cnt_d : '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            in_ready_q   <= 1'b1;
            out_valid_q  <= 1'b0;
            ke_en_q      <= 1'b0;
            ke_round_q   <= '0;
            dp_load_q    <= 1'b0;
            dp_en_q      <= 1'b0;
            dp_round_q   <= '0;
            dp_final_q   <= 1'b0;
            dp_decrypt_q <= 1'b0;
            key_valid_q  <= 1'b0;
            jobs_done_q  <= '0;
        end else begin
            state_q      <= state_d;
            in_ready_q   <= in_ready_d;
            out_valid_q  <= out_valid_d;
            ke_en_q      <= ke_en_d;
            ke_round_q   <= ke_round_d;
            dp_load_q    <= dp_load_d;
            dp_en_q      <= dp_en_d;
            dp_round_q   <= dp_round_d;
            dp_final_q   <= dp_final_d;
            dp_decrypt_q <= dp_decrypt_d;
            key_valid_q  <= key_valid_d;
            jobs_done_q  <= jobs_done_d;
        end
    end

    assign in_ready   = in_ready_q;
    assign out_valid  = out_valid_q;
    assign ke_en      = ke_en_q;
    assign ke_round   = ke_round_q;
    assign dp_load    = dp_load_q;
    assign dp_en      = dp_en_q;
    assign dp_round   = dp_round_q;
    assign dp_final   = dp_final_q;
    assign dp_decrypt = dp_decrypt_q;
    assign key_valid  = key_valid_q;
    assign jobs_done  = jobs_done_q;

endmodule

// File: tb/tb_aes128_seq_ctrl.sv
// Directed and randomized bench for aes128_seq_ctrl; each job's expected per-cycle
// control trace is rebuilt from the round schedule (key steps, load, rounds, final, done).
module tb_aes128_seq_ctrl;

    logic        clk = 1'b0;
    logic        reset, in_valid, in_decrypt, in_new_key, out_ready;
    logic        in_ready, ke_en, dp_load, dp_en, dp_final, dp_decrypt, out_valid, key_valid;
    logic [3:0]  ke_round, dp_round;
    logic [15:0] jobs_done;

    int errors = 0;
    int checks = 0;

    logic        kv_m;
    logic        dec_m;
    logic [15:0] jobs_m;

    aes128_seq_ctrl #(.NUM_ROUNDS(10)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_decrypt (in_decrypt),
        .in_new_key (in_new_key),
        .ke_en      (ke_en),
        .ke_round   (ke_round),
        .dp_load    (dp_load),
        .dp_en      (dp_en),
        .dp_round   (dp_round),
        .dp_final   (dp_final),
        .dp_decrypt (dp_decrypt),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .key_valid  (key_valid),
        .jobs_done  (jobs_done)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] pack(input logic ir, input logic ov, input logic ke,
                                         input logic [3:0] kr, input logic ld, input logic en,
                                         input logic [3:0] dr, input logic fin, input logic dec,
                                         input logic kv, input logic [15:0] jd);
        return {ir, ov, ke, kr, ld, en, dr, fin, dec, kv, jd};
    endfunction

    function automatic logic [31:0] obs();
        return pack(in_ready, out_valid, ke_en, ke_round, dp_load, dp_en, dp_round,
                    dp_final, dp_decrypt, key_valid, jobs_done);
    endfunction

    function automatic logic [31:0] idle_exp();
        return pack(1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, dec_m, kv_m, jobs_m);
    endfunction

    task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, o, e);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reset with accept and out_ready both requested: reset must win.
    task automatic hit_reset(input string tag);
        reset = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
        step();
        reset = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        kv_m = 1'b0; dec_m = 1'b0; jobs_m = 16'd0;
        chk(tag, obs(), idle_exp());
    endtask

    task automatic run_job(input logic dec, input logic nk, input int stall,
                           input bit noise, input int abort_at);
        logic        kexp, ke, ld, en, fin, ov, kvv;
        logic [3:0]  kr, dr;
        int          kx, j, first_ov;
        chk("idle_before_job", obs(), idle_exp());
        in_valid = 1'b1; in_decrypt = dec; in_new_key = nk; out_ready = 1'b0;
        step();
        kexp  = nk || !kv_m;
        kx    = kexp ? 10 : 0;
        dec_m = dec;
        first_ov = 0;
        for (int c = 1; c <= kx + 12; c++) begin
            j   = c - kx;
            ke  = (c <= kx);
            kr  = ke ? 4'(c) : 4'd0;
            ld  = (j == 1);
            en  = (j >= 2) && (j <= 11);
            fin = (j == 11);
            ov  = (j >= 12);
            if (ld)                  dr = dec ? 4'd10 : 4'd0;
            else if (en && !fin)     dr = dec ? 4'(11 - j) : 4'(j - 1);
            else if (fin)            dr = dec ? 4'd0 : 4'd10;
            else                     dr = 4'd0;
            kvv = kexp ? (c > kx) : 1'b1;
            if (out_valid && first_ov == 0) first_ov = c;
            chk($sformatf("job_cycle%0d", c), obs(),
                pack(1'b0, ov, ke, kr, ld, en, dr, fin, dec_m, kvv, jobs_m));
            if (c == abort_at) begin
                hit_reset("abort_to_idle");
                return;
            end
            if (c < kx + 12) begin
                if (noise) begin
                    in_valid   = 1'($urandom);
                    in_decrypt = 1'($urandom);
                    in_new_key = 1'($urandom);
                    out_ready  = 1'($urandom);
                end else begin
                    in_valid = 1'b0;
                end
                step();
            end
        end
        kv_m = 1'b1;
        chk("latency", 32'(first_ov), 32'(kx + 12));
        out_ready = 1'b0;
        for (int s = 0; s < stall; s++) begin
            in_valid   = 1'b1;
            in_new_key = 1'($urandom);
            step();
            chk("done_hold", obs(),
                pack(1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, dec_m, kv_m, jobs_m));
        end
        in_valid = 1'b0; out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        jobs_m = jobs_m + 16'd1;
        chk("done_exit", obs(), idle_exp());
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_decrypt = 1'b0; in_new_key = 1'b0; out_ready = 1'b0;
        kv_m = 1'b0; dec_m = 1'b0; jobs_m = 16'd0;
        repeat (3) step();
        chk("reset_held", obs(), idle_exp());
        reset = 1'b0;
        step();
        chk("reset_released", obs(), idle_exp());

        // Encrypt with fresh key, then key reuse, then decrypt on the same key.
        run_job(1'b0, 1'b1, 0, 1'b0, 0);
        run_job(1'b0, 1'b0, 0, 1'b0, 0);
        chk("jobs_after_two", {16'd0, jobs_done}, 32'd2);
        run_job(1'b1, 1'b0, 0, 1'b0, 0);
        run_job(1'b0, 1'b0, 5, 1'b0, 0);

        // Aborts mid-KEYEXP and mid-ROUND; a key-reuse job afterwards must re-expand.
        run_job(1'b0, 1'b1, 0, 1'b0, 4);
        run_job(1'b0, 1'b0, 0, 1'b0, 0);
        run_job(1'b1, 1'b0, 0, 1'b0, 6);
        run_job(1'b1, 1'b0, 2, 1'b0, 0);

        // Counter wrap: preset near the top, then two jobs.
        force dut.jobs_done_q = 16'hFFFE;
        step();
        release dut.jobs_done_q;
        jobs_m = 16'hFFFE;
        run_job(1'b0, 1'b0, 0, 1'b0, 0);
        run_job(1'b1, 1'b0, 1, 1'b0, 0);
        chk("jobs_wrapped", {16'd0, jobs_done}, 32'd0);

        for (int k = 0; k < 30; k++) begin
            run_job(1'($urandom), 1'($urandom), int'($urandom_range(0, 4)), 1'b1,
                    ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 21)) : 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
